imuldiv_div_arbiter: RTL and testbench
======================================

// Module: imuldiv_div_arbiter
// PURPOSE
//   Shares one iterative integer divider (32b operands, fn 0=unsigned/1=signed, 64b result {rem,quot})
//   between two requesters (e.g. two issue pipes). Round-robin grant, one operation in flight,
//   and each response is routed back to the requester that issued it. Sits between the requesters'
//   val/rdy ports and the divider's divreq/divresp ports.
// PARAMETERS
//   PRIO_INIT   0   requester that holds priority after reset (0 or 1)
// PORTS
//   clk                 in   1   clock
//   reset               in   1   synchronous, active-high reset
//   reqK_val            in   1   K=0,1: request valid
//   reqK_rdy            out  1   request accepted this cycle when reqK_val && reqK_rdy
//   reqK_msg_fn         in   1   0 unsigned, 1 signed
//   reqK_msg_a/_b       in   32  dividend / divisor
//   respK_val           out  1   response valid to requester K
//   respK_rdy           in   1   requester K can take response
//   respK_msg_result    out  64  {remainder[63:32], quotient[31:0]}
//   divreq_val          out  1   to divider
//   divreq_rdy          in   1   from divider
//   divreq_msg_fn/_a/_b out  1/32/32  granted request's fields
//   divresp_val         in   1   from divider
//   divresp_rdy         out  1   to divider
//   divresp_msg_result  in   64  divider result
// BEHAVIOUR
//   - State: IDLE, BUSY (op in divider), ZRESP (local response held); regs: prio, owner, zres[63:0].
//   - Reset: state=IDLE, prio=PRIO_INIT, owner=0. All *_val outputs low. reqK_rdy low unless the
//     IDLE grant rule below selects K.
//   - Grant (IDLE only, combinational): only one valid -> that one; both valid -> prio.
//   - IDLE: divreq_val = grant valid && grant b!=0. divreq_msg = granted req fields.
//     reqK_rdy = (grant==K) && reqK_val && (divreq_rdy || b==0).
//     A request is accepted when reqK_val && reqK_rdy. divreq_val never depends on divreq_rdy.
//   - On accept with b!=0: owner<=K, prio<=~K, ->BUSY.
//   - BUSY: all reqK_rdy=0, divreq_val=0. respK_val = divresp_val && owner==K.
//     respK_msg_result = divresp_msg_result. divresp_rdy = resp[owner]_rdy (combinational pass-through,
//     zero added latency). On divresp fire -> IDLE. New request accepted no earlier than next cycle.
//   - Throughput: one op per (divider latency + 1) cycles max; the arbiter adds no cycles in the request path.
//   - Fairness: with both requesters continuously valid, grants strictly alternate.
//   - Response backpressure: respK_rdy low holds BUSY/ZRESP indefinitely; the other requester is not served meanwhile.
//   - Reset mid-operation: returns to IDLE, in-flight op dropped, no response. The divider shares the reset.
//   - divresp_val while IDLE: ignored; divresp_rdy=0, no respK_val.
// CONFIGURATION
//   IMULDIV_DIVARB_ZERO_BYPASS_EN defined:
//     - A granted request with b==0 does not go to the divider (divreq_val=0).
//     - On accept: zres <= {a, 32'hFFFFFFFF}, owner<=K, prio<=~K, ->ZRESP.
//     - ZRESP: respK_val = (owner==K), result = zres, all reqK_rdy=0, divresp_rdy=0.
//       On resp fire -> IDLE (latency 1 cycle), for both signed and unsigned fn.
//   Not defined:
//     - The b==0 terms above are dropped. Zero divisors go to the divider like any other request.
//     - ZRESP is unreachable.
// TESTING
//   1 req0 {fn=1,a=-7,b=2} alone -> divreq issued, resp0 result {rem=-1,quot=-3}; resp1_val stays 0.
//   2 req0 and req1 valid same cycle after reset (PRIO_INIT=0) -> req0 granted first, then req1.
//     Each resp goes only to its own port.
//   3 Both valid for 6 ops -> grant order 0,1,0,1,0,1. No req*_rdy while BUSY.
//   4 resp1_rdy held low 10 cycles after divresp_val -> divresp_rdy=0, req0 stalled.
//     Releasing resp1_rdy completes the handshake in that cycle.
//   5 reset asserted 5 cycles into a BUSY op -> next cycle all val low, state IDLE, prio=PRIO_INIT.
//     No stale response is delivered afterwards.
//   6 (ZERO_BYPASS_EN) req1 {fn=0,a=123,b=0} -> divreq_val never asserted.
//     resp1 result 64'h0000007B_FFFFFFFF the cycle after accept.

Source files
------------

// File: rtl/imuldiv_div_arbiter_if.sv
// Handshake bundle between the divider arbiter, its two requesters and the shared divider.
// The master modport is the arbiter's view; slave is the requesters plus divider.
interface imuldiv_div_arbiter_if;
   logic        req0_val;
   logic        req0_rdy;
   logic        req0_msg_fn;
   logic [31:0] req0_msg_a;
   logic [31:0] req0_msg_b;
   logic        req1_val;
   logic        req1_rdy;
   logic        req1_msg_fn;
   logic [31:0] req1_msg_a;
   logic [31:0] req1_msg_b;
   logic        resp0_val;
   logic        resp0_rdy;
   logic [63:0] resp0_msg_result;
   logic        resp1_val;
   logic        resp1_rdy;
   logic [63:0] resp1_msg_result;
   logic        divreq_val;
   logic        divreq_rdy;
   logic        divreq_msg_fn;
   logic [31:0] divreq_msg_a;
   logic [31:0] divreq_msg_b;
   logic        divresp_val;
   logic        divresp_rdy;
   logic [63:0] divresp_msg_result;

   modport master (
      input  req0_val, req0_msg_fn, req0_msg_a, req0_msg_b,
      output req0_rdy,
      input  req1_val, req1_msg_fn, req1_msg_a, req1_msg_b,
      output req1_rdy,
      output resp0_val, resp0_msg_result,
      input  resp0_rdy,
      output resp1_val, resp1_msg_result,
      input  resp1_rdy,
      output divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b,
      input  divreq_rdy,
      input  divresp_val, divresp_msg_result,
      output divresp_rdy
   );

   modport slave (
      output req0_val, req0_msg_fn, req0_msg_a, req0_msg_b,
      input  req0_rdy,
      output req1_val, req1_msg_fn, req1_msg_a, req1_msg_b,
      input  req1_rdy,
      input  resp0_val, resp0_msg_result,
      output resp0_rdy,
      input  resp1_val, resp1_msg_result,
      output resp1_rdy,
      input  divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b,
      output divreq_rdy,
      output divresp_val, divresp_msg_result,
      input  divresp_rdy
   );
endinterface

// File: rtl/imuldiv_div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between two requesters.
// Define IMULDIV_DIVARB_ZERO_BYPASS_EN to answer zero-divisor requests locally.
module imuldiv_div_arbiter #(
   parameter bit PRIO_INIT = 1'b0
) (
   input logic                   clk,
   input logic                   reset,
   imuldiv_div_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      ZRESP
   } state_t;

   state_t      state;
   logic        prio;
   logic        owner;

   logic        gnt;
   logic        gnt_val;
   logic        gnt_fn;
   logic [31:0] gnt_a;
   logic [31:0] gnt_b;
   logic        bz;
   logic        acc;
   logic        fire;
   logic        own_rdy;
   logic [63:0] res;

   always_comb begin
      gnt_val = bus.req0_val | bus.req1_val;
      gnt     = (bus.req0_val & bus.req1_val) ? prio : bus.req1_val;
      gnt_fn  = gnt ? bus.req1_msg_fn : bus.req0_msg_fn;
      gnt_a   = gnt ? bus.req1_msg_a : bus.req0_msg_a;
      gnt_b   = gnt ? bus.req1_msg_b : bus.req0_msg_b;
   end

   assign own_rdy = owner ? bus.resp1_rdy : bus.resp0_rdy;

`ifdef IMULDIV_DIVARB_ZERO_BYPASS_EN
   logic [63:0] zres;

   assign bz  = (gnt_b == 32'd0);
   assign res = (state == ZRESP) ? zres : bus.divresp_msg_result;
`else
   assign bz  = 1'b0;
   assign res = bus.divresp_msg_result;
`endif

   assign bus.divreq_msg_fn    = gnt_fn;
   assign bus.divreq_msg_a     = gnt_a;
   assign bus.divreq_msg_b     = gnt_b;
   assign bus.resp0_msg_result = res;
   assign bus.resp1_msg_result = res;

   always_comb begin
      bus.req0_rdy    = 1'b0;
      bus.req1_rdy    = 1'b0;
      bus.divreq_val  = 1'b0;
      bus.resp0_val   = 1'b0;
      bus.resp1_val   = 1'b0;
      bus.divresp_rdy = 1'b0;
      acc             = 1'b0;
      fire            = 1'b0;
      unique case (state)
         IDLE: begin
            // divreq_val is kept independent of divreq_rdy
            bus.divreq_val = gnt_val & ~bz;
            acc            = gnt_val & (bus.divreq_rdy | bz);
            bus.req0_rdy   = acc & ~gnt;
            bus.req1_rdy   = acc & gnt;
         end
         BUSY: begin
            bus.resp0_val   = bus.divresp_val & ~owner;
            bus.resp1_val   = bus.divresp_val & owner;
            bus.divresp_rdy = own_rdy;
            fire            = bus.divresp_val & own_rdy;
         end
         ZRESP: begin
            bus.resp0_val = ~owner;
            bus.resp1_val = owner;
            fire          = own_rdy;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         prio  <= PRIO_INIT;
         owner <= 1'b0;
`ifdef IMULDIV_DIVARB_ZERO_BYPASS_EN
         zres  <= 64'd0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (acc) begin
                  owner <= gnt;
                  prio  <= ~gnt;
`ifdef IMULDIV_DIVARB_ZERO_BYPASS_EN
                  if (bz) begin
                     zres  <= {gnt_a, 32'hFFFF_FFFF};
                     state <= ZRESP;
                  end else begin
                     state <= BUSY;
                  end
`else
                  state <= BUSY;
`endif
               end
            end
            BUSY, ZRESP: begin
               if (fire) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imuldiv_div_arbiter.sv
// Directed bench for imuldiv_div_arbiter with a fixed-latency divider stand-in.
// Expected results are hand-computed constants.
module tb_imuldiv_div_arbiter;

   localparam int LAT = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   imuldiv_div_arbiter_if bus ();

   imuldiv_div_arbiter #(.PRIO_INIT(1'b0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // divider stand-in: one op at a time, LAT cycles, holds result until taken
   logic        dv_busy;
   logic [2:0]  dv_cnt;
   logic [63:0] dv_res;

   function automatic logic [63:0] div_ref(logic fn, logic [31:0] a, logic [31:0] b);
      logic signed [31:0] sa, sb, sq, sr;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (fn) begin
         sa = a; sb = b;
         sq = sa / sb; sr = sa % sb;
         return {sr, sq};
      end
      return {a % b, a / b};
   endfunction

   assign bus.divreq_rdy         = !dv_busy;
   assign bus.divresp_val        = dv_busy && (dv_cnt == 3'd0);
   assign bus.divresp_msg_result = dv_res;

   always @(posedge clk) begin
      if (reset) begin
         dv_busy <= 1'b0;
         dv_cnt  <= 3'd0;
         dv_res  <= 64'd0;
      end else if (!dv_busy && bus.divreq_val) begin
         dv_busy <= 1'b1;
         dv_cnt  <= 3'(LAT);
         dv_res  <= div_ref(bus.divreq_msg_fn, bus.divreq_msg_a, bus.divreq_msg_b);
      end else if (dv_busy) begin
         if (dv_cnt != 3'd0) dv_cnt <= dv_cnt - 3'd1;
         else if (bus.divresp_rdy) dv_busy <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic fn, input logic [31:0] a, input logic [31:0] b);
      if (k == 0) begin
         bus.req0_msg_fn = fn; bus.req0_msg_a = a; bus.req0_msg_b = b;
      end else begin
         bus.req1_msg_fn = fn; bus.req1_msg_a = a; bus.req1_msg_b = b;
      end
   endtask

   task automatic do_reset();
      bus.req0_val  = 1'b0;
      bus.req1_val  = 1'b0;
      bus.resp0_rdy = 1'b1;
      bus.resp1_rdy = 1'b1;
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      #1;
   endtask

   // waits for respK_val; also flags a wrong-port response or any req_rdy while busy
   task automatic wait_resp(input int k, input logic [63:0] exp, input string tag);
      int n;
      bit other, rdy_seen;
      logic mine, theirs;
      n = 0; other = 0; rdy_seen = 0;
      mine = (k == 1) ? bus.resp1_val : bus.resp0_val;
      while (!mine && n < 30) begin
         theirs = (k == 1) ? bus.resp0_val : bus.resp1_val;
         if (theirs) other = 1;
         if (bus.req0_rdy || bus.req1_rdy) rdy_seen = 1;
         cyc();
         n++;
         mine = (k == 1) ? bus.resp1_val : bus.resp0_val;
      end
      theirs = (k == 1) ? bus.resp0_val : bus.resp1_val;
      if (theirs) other = 1;
      if (bus.req0_rdy || bus.req1_rdy) rdy_seen = 1;
      check({tag, "_timeout"}, 64'(n < 30), 64'd1);
      check({tag, "_result"}, (k == 1) ? bus.resp1_msg_result : bus.resp0_msg_result, exp);
      check({tag, "_other_val"}, 64'(other), 64'd0);
      check({tag, "_rdy_busy"}, 64'(rdy_seen), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      bit   bad;
      logic g;

      set_req(0, 1'b0, 32'd0, 32'd1);
      set_req(1, 1'b0, 32'd0, 32'd1);
      do_reset();

      // reset state
      check("rst_req0_rdy", 64'(bus.req0_rdy), 64'd0);
      check("rst_req1_rdy", 64'(bus.req1_rdy), 64'd0);
      check("rst_resp_val", 64'({bus.resp1_val, bus.resp0_val}), 64'd0);
      check("rst_divreq_val", 64'(bus.divreq_val), 64'd0);
      check("rst_divresp_rdy", 64'(bus.divresp_rdy), 64'd0);

      // signed -7 / 2 from req0
      set_req(0, 1'b1, 32'hFFFF_FFF9, 32'd2);
      bus.req0_val = 1'b1;
      #1;
      check("t1_divreq_val", 64'(bus.divreq_val), 64'd1);
      check("t1_req0_rdy", 64'(bus.req0_rdy), 64'd1);
      check("t1_divreq_a", 64'(bus.divreq_msg_a), 64'hFFFF_FFF9);
      check("t1_divreq_fn", 64'(bus.divreq_msg_fn), 64'd1);
      cyc();
      bus.req0_val = 1'b0;
      wait_resp(0, 64'hFFFF_FFFF_FFFF_FFFD, "t1");
      cyc();

      // simultaneous requests after reset: req0 first
      do_reset();
      set_req(0, 1'b0, 32'd100, 32'd7);
      set_req(1, 1'b1, 32'hFFFF_FF9C, 32'd7);
      bus.req0_val = 1'b1;
      bus.req1_val = 1'b1;
      #1;
      check("t2_req0_rdy", 64'(bus.req0_rdy), 64'd1);
      check("t2_req1_rdy", 64'(bus.req1_rdy), 64'd0);
      cyc();
      bus.req0_val = 1'b0;
      #1;
      wait_resp(0, {32'd2, 32'd14}, "t2_r0");
      cyc();
      check("t2_req1_rdy_after", 64'(bus.req1_rdy), 64'd1);
      cyc();
      bus.req1_val = 1'b0;
      #1;
      wait_resp(1, 64'hFFFF_FFFE_FFFF_FFF2, "t2_r1");
      cyc();

      // fairness with both continuously valid
      do_reset();
      set_req(0, 1'b0, 32'd50, 32'd5);
      set_req(1, 1'b0, 32'd9, 32'd4);
      bus.req0_val = 1'b1;
      bus.req1_val = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         n = 0;
         while (!(bus.req0_rdy || bus.req1_rdy) && n < 30) begin
            cyc();
            n++;
         end
         check("t3_grant_timeout", 64'(n < 30), 64'd1);
         check("t3_grant_single", 64'(bus.req0_rdy & bus.req1_rdy), 64'd0);
         g = bus.req1_rdy;
         check("t3_grant", 64'(g), 64'(i % 2));
         cyc();
         if (g) wait_resp(1, {32'd1, 32'd2}, "t3_r1");
         else wait_resp(0, {32'd0, 32'd10}, "t3_r0");
         cyc();
      end
      bus.req0_val = 1'b0;
      bus.req1_val = 1'b0;

      // response backpressure on port 1 stalls everything
      do_reset();
      bus.resp1_rdy = 1'b0;
      set_req(1, 1'b0, 32'd9, 32'd4);
      bus.req1_val = 1'b1;
      #1;
      cyc();
      bus.req1_val = 1'b0;
      set_req(0, 1'b0, 32'd50, 32'd5);
      bus.req0_val = 1'b1;
      #1;
      wait_resp(1, {32'd1, 32'd2}, "t4_r1");
      bad = 0;
      repeat (10) begin
         if (bus.divresp_rdy || bus.req0_rdy || !bus.resp1_val) bad = 1;
         cyc();
      end
      check("t4_stall", 64'(bad), 64'd0);
      bus.resp1_rdy = 1'b1;
      #1;
      check("t4_divresp_rdy", 64'(bus.divresp_rdy), 64'd1);
      cyc();
      check("t4_req0_rdy_after", 64'(bus.req0_rdy), 64'd1);
      cyc();
      bus.req0_val = 1'b0;
      #1;
      wait_resp(0, {32'd0, 32'd10}, "t4_r0");
      cyc();

      // reset in the middle of an operation
      do_reset();
      set_req(0, 1'b0, 32'd50, 32'd5);
      bus.req0_val = 1'b1;
      #1;
      cyc();
      bus.req0_val = 1'b0;
      repeat (5) cyc();
      reset = 1'b1;
      cyc();
      check("t5_vals", 64'({bus.resp1_val, bus.resp0_val, bus.divreq_val}), 64'd0);
      check("t5_divresp_rdy", 64'(bus.divresp_rdy), 64'd0);
      reset = 1'b0;
      bad = 0;
      repeat (20) begin
         cyc();
         if (bus.resp0_val || bus.resp1_val || bus.divresp_rdy) bad = 1;
      end
      check("t5_stale", 64'(bad), 64'd0);
      bus.req0_val = 1'b1;
      bus.req1_val = 1'b1;
      #1;
      check("t5_prio_req0", 64'(bus.req0_rdy), 64'd1);
      check("t5_prio_req1", 64'(bus.req1_rdy), 64'd0);
      bus.req0_val = 1'b0;
      bus.req1_val = 1'b0;
      cyc();

      // zero divisor from req1
      do_reset();
      set_req(1, 1'b0, 32'd123, 32'd0);
      bus.req1_val = 1'b1;
      #1;
`ifdef IMULDIV_DIVARB_ZERO_BYPASS_EN
      check("t6_divreq_val", 64'(bus.divreq_val), 64'd0);
      check("t6_req1_rdy", 64'(bus.req1_rdy), 64'd1);
      cyc();
      bus.req1_val = 1'b0;
      #1;
      check("t6_resp1_val", 64'(bus.resp1_val), 64'd1);
      check("t6_resp0_val", 64'(bus.resp0_val), 64'd0);
      check("t6_result", bus.resp1_msg_result, 64'h0000_007B_FFFF_FFFF);
      check("t6_divreq_quiet", 64'(bus.divreq_val), 64'd0);
      cyc();
      check("t6_resp1_done", 64'(bus.resp1_val), 64'd0);
`else
      check("t6_divreq_val", 64'(bus.divreq_val), 64'd1);
      check("t6_req1_rdy", 64'(bus.req1_rdy), 64'd1);
      cyc();
      bus.req1_val = 1'b0;
      #1;
      wait_resp(1, 64'h0000_007B_FFFF_FFFF, "t6");
      cyc();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
